// File: rtl/prio_req_capture_if.sv
// Request-capture bus: request lines, mask load, ack return, and
// pending/status outputs toward the priority encoder.
interface prio_req_capture_if;
    logic [3:0]  req_in;
    logic        mask_wr;
    logic [3:0]  mask_in;
    logic        ack;
    logic [2:0]  ack_id;
    logic [3:0]  r;
    logic        irq;
    logic [3:0]  pend;
    logic [31:0] drop_cnt;

    modport master (
        output req_in, mask_wr, mask_in, ack, ack_id,
        input  r, irq, pend, drop_cnt
    );

    modport slave (
        input  req_in, mask_wr, mask_in, ack, ack_id,
        output r, irq, pend, drop_cnt
    );
endinterface

// File: rtl/prio_req_capture.sv
// prio_req_capture: synchronizes four async request lines, captures
// rising edges (or levels) into sticky pending bits, presents the masked
// vector r to the downstream priority encoder, and clears a bit on ack.
// Optional dropped-event counters are built when PRIO_REQ_DROP_CNT_EN
// is defined; otherwise drop_cnt is tied to zero.
module prio_req_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    prio_req_capture_if.slave  bus
);

    // Set events are suppressed until the synchronizer and history flop
    // hold values sampled after reset release, so a line already high at
    // release is not mistaken for a new edge.
    localparam logic [2:0] WARM_INIT = 3'(SYNC_STAGES + 1);

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] s_prev_q;
    logic [2:0] warm_q;
    logic [3:0] pend_q, pend_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] s;
    logic [3:0] set_ev;
    logic [3:0] clr_ev;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchronizer chains, edge history and post-reset warm-up down-counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_prev_q <= '0;
            warm_q   <= WARM_INIT;
        end else begin
            sync_q[0] <= bus.req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_prev_q <= s;
            if (warm_q != 3'd0) begin
                warm_q <= warm_q - 3'd1;
            end
        end
    end

    // Set/clear decode and next pending/mask values; set beats clear.
    always_comb begin
        set_ev = '0;
        if (warm_q == 3'd0) begin
            set_ev = (EDGE_MODE != 0) ? (s & ~s_prev_q) : s;
        end

        clr_ev = '0;
        if (bus.ack) begin
            case (bus.ack_id)
                3'd1:    clr_ev = 4'b0001;
                3'd2:    clr_ev = 4'b0010;
                3'd3:    clr_ev = 4'b0100;
                3'd4:    clr_ev = 4'b1000;
                default: clr_ev = 4'b0000;
            endcase
        end

        pend_d = (pend_q & ~clr_ev) | set_ev;
        mask_d = bus.mask_wr ? bus.mask_in : mask_q;
    end

    // Pending and mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            mask_q <= 4'b1111;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

    assign bus.pend = pend_q;
    assign bus.r    = pend_q & mask_q;
    assign bus.irq  = |(pend_q & mask_q);

`ifdef PRIO_REQ_DROP_CNT_EN
    logic [3:0][7:0] drop_q, drop_d;

    // Count events that land on an already-pending, uncleared line;
    // masking a line off clears its counter.
    always_comb begin
        drop_d = drop_q;
        for (int i = 0; i < 4; i++) begin
            if (bus.mask_wr && !bus.mask_in[i]) begin
                drop_d[i] = 8'h00;
            end else if (set_ev[i] && pend_q[i] && !clr_ev[i] && (drop_q[i] != 8'hFF)) begin
                drop_d[i] = drop_q[i] + 8'd1;
            end
        end
    end

    // Dropped-event counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_prio_req_capture.sv
// Testbench for prio_req_capture: directed vector table, hand-written
// reset/mask/drop sequences, and randomized traffic against a model that
// derives pending state from the input history delayed by the sync depth.
module tb_prio_req_capture;

    localparam int S    = 2;
    localparam int EDGE = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    prio_req_capture_if bus();

    prio_req_capture #(.SYNC_STAGES(S), .EDGE_MODE(EDGE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [3:0] hist [$];
    int         n;
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    int         m_cnt [4];

    typedef struct {
        logic [3:0] req;
        logic       mwr;
        logic [3:0] mi;
        logic       ak;
        logic [2:0] aid;
        logic [3:0] e_pend;
        logic [3:0] e_r;
        logic       e_irq;
    } vec_t;

    vec_t tbl [30];

    function automatic logic [31:0] m_drop();
        logic [31:0] v;
        v = 32'h0;
`ifdef PRIO_REQ_DROP_CNT_EN
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = m_cnt[i][7:0];
`endif
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(4'h0);
        n = 0;
        m_pend = 4'h0;
        m_mask = 4'hF;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic mwr, input logic [3:0] mi,
                              input logic ak, input logic [2:0] aid);
        logic [3:0] set, clr;
        n++;
        hist.push_back(req);
        set = 4'h0;
        if (n >= S + 2) begin
            if (EDGE != 0) set = hist[n-S] & ~hist[n-S-1];
            else           set = hist[n-S];
        end
        clr = 4'h0;
        if (ak && aid >= 3'd1 && aid <= 3'd4) clr[aid-3'd1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mwr && !mi[i]) m_cnt[i] = 0;
            else if (set[i] && m_pend[i] && !clr[i]) m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
        end
        m_pend = (m_pend & ~clr) | set;
        if (mwr) m_mask = mi;
    endtask

    task automatic check_model();
        logic [3:0] er;
        er = m_pend & m_mask;
        checks++;
        if (bus.pend !== m_pend || bus.r !== er || bus.irq !== (|er) || bus.drop_cnt !== m_drop()) begin
            errors++;
            $display("FAIL model n=%0d pend %b exp %b r %b exp %b irq %b exp %b drop %h exp %h",
                     n, bus.pend, m_pend, bus.r, er, bus.irq, |er, bus.drop_cnt, m_drop());
        end
    endtask

    task automatic cycle(input logic [3:0] req, input logic mwr, input logic [3:0] mi,
                         input logic ak, input logic [2:0] aid);
        bus.req_in  = req;
        bus.mask_wr = mwr;
        bus.mask_in = mi;
        bus.ack     = ak;
        bus.ack_id  = aid;
        @(posedge clk);
        model_step(req, mwr, mi, ak, aid);
        #1;
        check_model();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(4'h0, 1'b0, 4'hF, 1'b0, 3'd0);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Assert reset now, verify outputs drop immediately, then release with
    // req held at hold_req and run the warm-up cycles.
    task automatic do_reset(input logic [3:0] hold_req);
        reset_n     = 1'b0;
        bus.req_in  = hold_req;
        bus.mask_wr = 1'b0;
        bus.mask_in = 4'hF;
        bus.ack     = 1'b0;
        bus.ack_id  = 3'd0;
        #1;
        check_val("reset_out", {bus.pend, bus.r, 3'b0, bus.irq, bus.drop_cnt[19:0]},
                  32'h0);
        check_val("reset_drop", bus.drop_cnt, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) cycle(hold_req, 1'b0, 4'hF, 1'b0, 3'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cur;
        logic [3:0] r4;
        tbl[0]  = '{4'b0100, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0100, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0100, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0100, 4'b0100, 1'b1};
        tbl[3]  = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0100, 4'b0100, 1'b1};
        tbl[4]  = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0100, 4'b0100, 1'b1};
        tbl[5]  = '{4'b0000, 1'b0, 4'hF, 1'b1, 3'd3, 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{4'b1001, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b1001, 4'b1001, 1'b1};
        tbl[9]  = '{4'b0000, 1'b0, 4'hF, 1'b1, 3'd4, 4'b0001, 4'b0001, 1'b1};
        tbl[10] = '{4'b0000, 1'b0, 4'hF, 1'b1, 3'd1, 4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{4'b0010, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0010, 4'b0010, 1'b1};
        tbl[14] = '{4'b0010, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0010, 4'b0010, 1'b1};
        tbl[15] = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0010, 4'b0010, 1'b1};
        tbl[16] = '{4'b0000, 1'b0, 4'hF, 1'b1, 3'd2, 4'b0010, 4'b0010, 1'b1};
        tbl[17] = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0010, 4'b0010, 1'b1};
        tbl[18] = '{4'b0000, 1'b0, 4'hF, 1'b1, 3'd2, 4'b0000, 4'b0000, 1'b0};
        tbl[19] = '{4'b0000, 1'b1, 4'b0111, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[20] = '{4'b1000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[21] = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[22] = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b1000, 4'b0000, 1'b0};
        tbl[23] = '{4'b0000, 1'b1, 4'b1111, 1'b0, 3'd0, 4'b1000, 4'b1000, 1'b1};
        tbl[24] = '{4'b1111, 1'b0, 4'hF, 1'b0, 3'd0, 4'b1000, 4'b1000, 1'b1};
        tbl[25] = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b1000, 4'b1000, 1'b1};
        tbl[26] = '{4'b0000, 1'b0, 4'hF, 1'b0, 3'd0, 4'b1111, 4'b1111, 1'b1};
        tbl[27] = '{4'b0000, 1'b0, 4'hF, 1'b1, 3'd0, 4'b1111, 4'b1111, 1'b1};
        tbl[28] = '{4'b0000, 1'b0, 4'hF, 1'b1, 3'd7, 4'b1111, 4'b1111, 1'b1};
        tbl[29] = '{4'b0000, 1'b0, 4'hF, 1'b1, 3'd5, 4'b1111, 4'b1111, 1'b1};

        model_reset();
        do_reset(4'h0);

        // directed vector table
        for (int i = 0; i < 30; i++) begin
            cycle(tbl[i].req, tbl[i].mwr, tbl[i].mi, tbl[i].ak, tbl[i].aid);
            checks++;
            if (bus.pend !== tbl[i].e_pend || bus.r !== tbl[i].e_r || bus.irq !== tbl[i].e_irq) begin
                errors++;
                $display("FAIL vec%0d pend %b exp %b r %b exp %b irq %b exp %b",
                         i, bus.pend, tbl[i].e_pend, bus.r, tbl[i].e_r, bus.irq, tbl[i].e_irq);
            end
        end

        // mid-stream reset with every line held high through release
        @(negedge clk);
        do_reset(4'b1111);
        cycle(4'b1111, 1'b0, 4'hF, 1'b0, 3'd0);
        cycle(4'b1111, 1'b0, 4'hF, 1'b0, 3'd0);
        check_val("no_edge_at_release", {28'h0, bus.pend}, 32'h0);
        idle(3);
        cycle(4'b0001, 1'b0, 4'hF, 1'b0, 3'd0);
        idle(2);
        check_val("mask_after_reset_r", {28'h0, bus.r}, 32'h1);
        cycle(4'h0, 1'b0, 4'hF, 1'b1, 3'd1);
        check_val("ack_line1", {28'h0, bus.pend}, 32'h0);

        // 300 edges on line 3 with no ack
        for (int k = 0; k < 300; k++) begin
            cycle(4'b0100, 1'b0, 4'hF, 1'b0, 3'd0);
            cycle(4'b0000, 1'b0, 4'hF, 1'b0, 3'd0);
        end
        idle(2);
        check_val("drop_pend", {28'h0, bus.pend}, 32'h4);
`ifdef PRIO_REQ_DROP_CNT_EN
        check_val("drop_sat", bus.drop_cnt, 32'h00FF_0000);
`else
        check_val("drop_sat", bus.drop_cnt, 32'h0);
`endif
        cycle(4'h0, 1'b1, 4'b1011, 1'b0, 3'd0);
        check_val("drop_clear", bus.drop_cnt, 32'h0);
        check_val("masked_pend_kept", {24'h0, bus.pend, bus.r}, 32'h40);
        cycle(4'h0, 1'b1, 4'b1111, 1'b1, 3'd3);

        // randomized traffic against the model
        cur = 4'h0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                r4  = 4'($urandom_range(0, 15));
                cur = cur ^ r4;
            end
            cycle(cur,
                  ($urandom_range(0, 15) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
